// File: rtl/cache_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_pmem_arbiter
//
// Shares the single burst physical-memory port between the I-cache (read-only)
// and the D-cache (read/write). It serves one cacheline transaction at a time.
// The D-cache has priority. An anti-starvation limit forces an I grant after
// MAX_D_STREAK consecutive D grants taken while the I-cache was waiting.
// Grant and conflict counters are exported for performance reporting.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   i_read/i_addr   I-cache line read request and its address
//   i_rdata/i_resp  line data and one-cycle completion to the I-cache
//   d_read/d_write  D-cache line read / write-back request
//   d_addr/d_wdata  D-cache line address and write-back line
//   d_rdata/d_resp  line data and one-cycle completion to the D-cache
//   pmem_*          burst memory port (strobes, address and wdata are registered)
//   busy            a transaction is in flight
//   cnt_*           I grants, D grants, and IDLE cycles with both caches pending
// -----------------------------------------------------------------------------
module cache_pmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int MAX_D_STREAK = 4,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_i_grants,
  output logic [CNT_W-1:0]  cnt_d_grants,
  output logic [CNT_W-1:0]  cnt_conflicts
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  // The streak counter only needs to reach MAX_D_STREAK, where it saturates.
  localparam int              SW           = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_LIMIT = SW'(MAX_D_STREAK);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [SW-1:0]     d_streak;
  logic [ADDR_W-1:0] cap_addr;
  logic [LINE_W-1:0] cap_wdata;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic d_pend;
  logic i_pend;
  logic force_i;

  assign d_pend  = d_read | d_write;
  assign i_pend  = i_read;
  // With MAX_D_STREAK == 0 the I-cache is never forced: pure D priority.
  assign force_i = (MAX_D_STREAK != 0) && (d_streak >= STREAK_LIMIT);

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (d_pend && !(i_pend && force_i)) state_nxt = SERVE_D;
        else if (i_pend)                    state_nxt = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the wide capture and read-data holding registers are reset too, so no X is ever presented on the ports after reset.
      state         <= IDLE;
      d_streak      <= '0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      pmem_read     <= 1'b0;
      pmem_write    <= 1'b0;
      cnt_i_grants  <= '0;
      cnt_d_grants  <= '0;
      cnt_conflicts <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (i_pend && d_pend) cnt_conflicts <= cnt_conflicts + CNT_W'(1);
        if (state_nxt == SERVE_D) begin
          // A simultaneous read and write request is served as a write-back.
          cap_addr     <= d_addr;
          cap_wdata    <= d_wdata;
          pmem_write   <= d_write;
          pmem_read    <= ~d_write;
          cnt_d_grants <= cnt_d_grants + CNT_W'(1);
          if (i_read && (d_streak < STREAK_LIMIT)) d_streak <= d_streak + SW'(1);
        end else if (state_nxt == SERVE_I) begin
          cap_addr     <= i_addr;
          pmem_read    <= 1'b1;
          pmem_write   <= 1'b0;
          cnt_i_grants <= cnt_i_grants + CNT_W'(1);
          d_streak     <= '0;
        end
      end else if (pmem_resp) begin
        // Strobes drop at the same edge that returns the FSM to IDLE.
        pmem_read  <= 1'b0;
        pmem_write <= 1'b0;
        if (state == SERVE_I) i_rdata_q <= pmem_rdata;
        else                  d_rdata_q <= pmem_rdata;
      end
    end
  end

  // Completion is combinational with pmem_resp; the holding registers keep
  // the last delivered line visible to each cache between transactions.
  assign i_resp       = (state == SERVE_I) && pmem_resp;
  assign d_resp       = (state == SERVE_D) && pmem_resp;
  assign i_rdata      = i_resp ? pmem_rdata : i_rdata_q;
  assign d_rdata      = d_resp ? pmem_rdata : d_rdata_q;
  assign pmem_address = cap_addr;
  assign pmem_wdata   = cap_wdata;
  assign busy         = (state != IDLE);

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (rst) !((state == IDLE) && pmem_resp));

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_pmem_arbiter
//
// Directed stimulus for cache_pmem_arbiter. Each test pushes its hand-ordered
// expected transactions into two queues. The memory model pops the grant queue
// when a burst starts. The response monitor pops the response queue whenever
// i_resp or d_resp is seen. Counter values are hand-computed per test.
// -----------------------------------------------------------------------------
module tb_cache_pmem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 32;

  typedef struct {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  logic          busy;
  logic [CW-1:0] cnt_i_grants;
  logic [CW-1:0] cnt_d_grants;
  logic [CW-1:0] cnt_conflicts;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  txn_t exp_grant[$];
  txn_t exp_resp[$];

  cache_pmem_arbiter #(
    .ADDR_W(AW), .LINE_W(LW), .MAX_D_STREAK(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy), .cnt_i_grants(cnt_i_grants), .cnt_d_grants(cnt_d_grants),
    .cnt_conflicts(cnt_conflicts)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: each line is a pattern derived from its address.
  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_txn(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                            input logic [LW-1:0] wdata, input bit with_resp);
    txn_t t;
    t.is_d = is_d; t.wr = wr; t.addr = addr; t.wdata = wdata;
    exp_grant.push_back(t);
    if (with_resp) exp_resp.push_back(t);
  endtask

  task automatic check_counters(input string tag, input int ei, input int ed, input int ec);
    check({tag, "_cnt_i"}, cnt_i_grants, ei);
    check({tag, "_cnt_d"}, cnt_d_grants, ed);
    check({tag, "_cnt_conf"}, cnt_conflicts, ec);
  endtask

  // I-cache driver: hold until i_resp, drop the cycle after.
  task automatic i_txn(input logic [AW-1:0] addr);
    bit got = 1'b0;
    i_addr = addr;
    i_read = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      got = i_resp;
    end
    check("i_resp_seen", got, 1);
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  // D-cache driver; with hold set the request stays high into the turnaround
  // cycle so the next call presents a back-to-back request.
  task automatic d_txn(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                       input bit hold);
    bit got = 1'b0;
    d_addr  = addr;
    d_wdata = wdata;
    d_write = wr;
    d_read  = ~wr;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      got = d_resp;
    end
    check("d_resp_seen", got, 1);
    @(posedge clk); #1;
    if (!hold) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end
  endtask

  // Memory model: fixed latency, checks each burst against the grant queue.
  initial begin
    bit            mem_busy = 1'b0;
    int            mem_cnt  = 0;
    int            resp_cyc = -10;
    logic [AW-1:0] mem_addr = '0;
    txn_t          g;
    forever begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        mem_busy  = 1'b0;
      end else if (mem_busy) begin
        if (!(pmem_read || pmem_write)) begin
          mem_busy = 1'b0;
        end else begin
          check("pmem_addr_stable", pmem_address, mem_addr);
          if (mem_cnt == 0) begin
            pmem_rdata = mem_line(pmem_address);
            pmem_resp  = 1'b1;
            resp_cyc   = cyc;
          end else begin
            mem_cnt--;
          end
        end
      end else if (pmem_read || pmem_write) begin
        mem_busy = 1'b1;
        mem_addr = pmem_address;
        mem_cnt  = 2;
        check("turnaround_idle", (cyc - resp_cyc) >= 2, 1);
        check("pmem_one_op", pmem_read ^ pmem_write, 1);
        check("grant_expected", exp_grant.size() > 0, 1);
        if (exp_grant.size() > 0) begin
          g = exp_grant.pop_front();
          check("grant_addr", pmem_address, g.addr);
          check("grant_write", pmem_write, g.wr);
          if (g.wr) check("grant_wdata", pmem_wdata, g.wdata);
        end
      end
    end
  end

  // Response monitor.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        check("single_resp", i_resp && d_resp, 0);
        check("resp_expected", exp_resp.size() > 0, 1);
        if (exp_resp.size() > 0) begin
          e = exp_resp.pop_front();
          check("resp_port_is_d", d_resp, e.is_d);
          if (!e.wr && e.is_d)  check("d_rdata", d_rdata, mem_line(e.addr));
          if (!e.wr && !e.is_d) check("i_rdata", i_rdata, mem_line(e.addr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_addr", pmem_address, 0);
    check("rst_i_rdata", i_rdata, 0);
    check_counters("rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: lone I read, registered one-cycle grant latency.
    expect_txn(1'b0, 1'b0, 32'h60, '0, 1'b1);
    fork
      i_txn(32'h60);
      begin
        check("t1_no_early_read", pmem_read, 0);
        @(posedge clk); #1;
        check("t1_pmem_read", pmem_read, 1);
        check("t1_pmem_addr", pmem_address, 32'h60);
      end
    join
    check_counters("t1", 1, 0, 0);

    // 2: lone D write-back; I-cache data holds its last line.
    expect_txn(1'b1, 1'b1, 32'h1000, {32{8'hA5}}, 1'b1);
    d_txn(1'b1, 32'h1000, {32{8'hA5}}, 1'b0);
    check("t2_i_rdata_hold", i_rdata, mem_line(32'h60));
    check_counters("t2", 1, 1, 0);

    // 3: simultaneous requests: D first, then I after the turnaround cycle.
    expect_txn(1'b1, 1'b0, 32'h1100, '0, 1'b1);
    expect_txn(1'b0, 1'b0, 32'h80, '0, 1'b1);
    fork
      i_txn(32'h80);
      d_txn(1'b0, 32'h1100, '0, 1'b0);
    join
    check_counters("t3", 2, 2, 1);

    // 4: D streams back-to-back while I waits: D,D,D,D,I then the last D.
    for (int k = 0; k < 4; k++) expect_txn(1'b1, 1'b0, 32'h4000 + 32'(k * 64), '0, 1'b1);
    expect_txn(1'b0, 1'b0, 32'h500, '0, 1'b1);
    expect_txn(1'b1, 1'b0, 32'h4100, '0, 1'b1);
    fork
      i_txn(32'h500);
      for (int k = 0; k < 5; k++) d_txn(1'b0, 32'h4000 + 32'(k * 64), '0, k < 4);
    join
    check_counters("t4", 3, 7, 6);
    check("t4_streak_cleared", dut.d_streak, 0);

    // 5: reset in the middle of a D burst, then a fresh I read.
    expect_txn(1'b1, 1'b0, 32'h3000, '0, 1'b0);
    d_addr = 32'h3000;
    d_read = 1'b1;
    @(posedge clk); #1;
    check("t5_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_pmem_read", pmem_read, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_d_resp", d_resp, 0);
    check("t5_rst_d_rdata", d_rdata, 0);
    check_counters("t5_rst", 0, 0, 0);
    d_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    expect_txn(1'b0, 1'b0, 32'h700, '0, 1'b1);
    i_txn(32'h700);
    check_counters("t5", 1, 0, 0);

    // 6: D address changes during SERVE_D; the captured address is kept.
    expect_txn(1'b1, 1'b0, 32'h2000, '0, 1'b1);
    fork
      d_txn(1'b0, 32'h2000, '0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        d_addr = 32'hDEAD_0040;
        check("t6_pmem_addr_kept", pmem_address, 32'h2000);
      end
    join
    check("t6_d_rdata_hold", d_rdata, mem_line(32'h2000));
    check_counters("t6", 1, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("grant_queue_empty", exp_grant.size(), 0);
    check("resp_queue_empty", exp_resp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
